// File: rtl/my_struct_package.sv
// Shared types for the snoop responder: MESI states, bus op codes, snoop results
// and the responder FSM encoding.
package my_struct_package;

  localparam int WB_BEATS_DEFAULT = 8;

  typedef enum logic [1:0] {
    M = 2'd0,
    E = 2'd1,
    S = 2'd2,
    I = 2'd3
  } states_t;

  typedef enum logic [2:0] {
    OP_READ       = 3'd1,
    OP_WRITE      = 3'd2,
    OP_INVALIDATE = 3'd3,
    OP_RFO        = 3'd4
  } bus_op_t;

  typedef enum logic [1:0] {
    NOHIT = 2'd0,
    HIT   = 2'd1,
    HITM  = 2'd2
  } snoop_result_t;

  typedef enum logic [1:0] {
    FSM_IDLE    = 2'd0,
    FSM_RESPOND = 2'd1,
    FSM_WB      = 2'd2
  } fsm_state_t;

  // A hit on an Invalid line is treated exactly like a miss.
  function automatic logic line_present(input logic hit, input states_t mesi);
    return hit && (mesi != I);
  endfunction

endpackage

// File: rtl/snoop_resp_decode.sv
// Combinational snoop result / MESI next-state table.
// Protocol-violation reporting is compiled in only when SNOOP_PROTO_CHECK_EN is defined.
module snoop_resp_decode
  import my_struct_package::*;
(
  input  logic [2:0]    op_i,
  input  logic          hit_i,
  input  states_t       mesi_i,
  output snoop_result_t result_o,
  output logic          mesi_we_o,
  output states_t       mesi_next_o,
  output logic          need_wb_o,
  output logic          proto_err_o
);

`ifdef SNOOP_PROTO_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  logic violation;

  always_comb begin
    result_o    = NOHIT;
    mesi_we_o   = 1'b0;
    mesi_next_o = I;
    need_wb_o   = 1'b0;
    violation   = 1'b0;
    if (line_present(hit_i, mesi_i)) begin
      case (op_i)
        OP_READ: begin
          result_o    = (mesi_i == M) ? HITM : HIT;
          mesi_we_o   = 1'b1;
          mesi_next_o = S;
          need_wb_o   = (mesi_i == M);
        end
        OP_RFO: begin
          result_o    = (mesi_i == M) ? HITM : HIT;
          mesi_we_o   = 1'b1;
          mesi_next_o = I;
          need_wb_o   = (mesi_i == M);
        end
        OP_INVALIDATE: begin
          // Another agent invalidating an owned (E/M) line means ownership was lost track of.
          mesi_we_o   = 1'b1;
          mesi_next_o = I;
          violation   = (mesi_i != S);
        end
        default: violation = 1'b1;
      endcase
    end
  end

  assign proto_err_o = CHECK_EN && violation;

endmodule

// File: rtl/snoop_responder.sv
// Snoop responder: accepts one snooped bus op, answers the next cycle and, for a
// Modified hit, streams the line back in WB_BEATS beats. Optional: SNOOP_PROTO_CHECK_EN.
module snoop_responder
  import my_struct_package::*;
#(
  parameter int WB_BEATS = WB_BEATS_DEFAULT,
  parameter int ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              snoop_valid,
  output logic              snoop_ready,
  input  logic [2:0]        snoop_op,
  input  logic [ADDR_W-1:0] snoop_addr,
  input  logic              line_hit,
  input  states_t           line_mesi,
  output logic              result_valid,
  output snoop_result_t     snoop_result,
  output logic              mesi_we,
  output states_t           mesi_next,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [ADDR_W-1:0] wb_addr,
  output logic              wb_last,
  output logic              proto_err
);

  localparam int                BW        = $clog2(WB_BEATS);
  localparam logic [BW-1:0]     LAST_BEAT = BW'(WB_BEATS - 1);
  localparam logic [ADDR_W-1:0] BEAT_MASK = ADDR_W'(WB_BEATS - 1);

  fsm_state_t        state_q;
  logic              ready_q;
  logic              result_valid_q;
  snoop_result_t     result_q;
  logic              mesi_we_q;
  states_t           mesi_next_q;
  logic              proto_err_q;
  logic              wb_pend_q;
  logic              wb_valid_q;
  logic [ADDR_W-1:0] addr_q;
  logic [BW-1:0]     beat_q;
  logic [BW-1:0]     beat_d;

  snoop_result_t dec_result;
  logic          dec_we;
  states_t       dec_next;
  logic          dec_wb;
  logic          dec_err;

  snoop_resp_decode u_decode (
    .op_i        (snoop_op),
    .hit_i       (line_hit),
    .mesi_i      (line_mesi),
    .result_o    (dec_result),
    .mesi_we_o   (dec_we),
    .mesi_next_o (dec_next),
    .need_wb_o   (dec_wb),
    .proto_err_o (dec_err)
  );

  // Power-of-two beat count: the counter wraps back to 0 on the last accepted beat.
  assign beat_d = (wb_valid_q && wb_ready) ? beat_q + 1'b1 : beat_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= FSM_IDLE;
      ready_q        <= 1'b1;
      result_valid_q <= 1'b0;
      result_q       <= NOHIT;
      mesi_we_q      <= 1'b0;
      mesi_next_q    <= M;
      proto_err_q    <= 1'b0;
      wb_pend_q      <= 1'b0;
      wb_valid_q     <= 1'b0;
      addr_q         <= '0;
      beat_q         <= '0;
    end else begin
      result_valid_q <= 1'b0;
      mesi_we_q      <= 1'b0;
      proto_err_q    <= 1'b0;
      beat_q         <= beat_d;
      case (state_q)
        FSM_IDLE: begin
          if (snoop_valid) begin
            state_q        <= FSM_RESPOND;
            ready_q        <= 1'b0;
            addr_q         <= snoop_addr;
            result_valid_q <= 1'b1;
            result_q       <= dec_result;
            mesi_we_q      <= dec_we;
            mesi_next_q    <= dec_next;
            proto_err_q    <= dec_err;
            wb_pend_q      <= dec_wb;
          end
        end
        FSM_RESPOND: begin
          wb_pend_q <= 1'b0;
          if (wb_pend_q) begin
            state_q    <= FSM_WB;
            wb_valid_q <= 1'b1;
          end else begin
            state_q <= FSM_IDLE;
            ready_q <= 1'b1;
          end
        end
        FSM_WB: begin
          if (wb_ready && (beat_q == LAST_BEAT)) begin
            state_q    <= FSM_IDLE;
            wb_valid_q <= 1'b0;
            ready_q    <= 1'b1;
          end
        end
        default: begin
          state_q    <= FSM_IDLE;
          wb_valid_q <= 1'b0;
          ready_q    <= 1'b1;
        end
      endcase
    end
  end

  assign snoop_ready  = ready_q;
  assign result_valid = result_valid_q;
  assign snoop_result = result_q;
  assign mesi_we      = mesi_we_q;
  assign mesi_next    = mesi_next_q;
  assign proto_err    = proto_err_q;
  assign wb_valid     = wb_valid_q;
  assign wb_addr      = (addr_q & ~BEAT_MASK) | ADDR_W'(beat_q);
  assign wb_last      = wb_valid_q && (beat_q == LAST_BEAT);

endmodule

// File: tb/tb_snoop_responder.sv
// Self-checking bench for snoop_responder: directed scenarios plus random snoops
// compared against a rule-level reference model. Honours SNOOP_PROTO_CHECK_EN.
module tb_snoop_responder;
  import my_struct_package::*;

  localparam int N  = 8;
  localparam int AW = 32;

`ifdef SNOOP_PROTO_CHECK_EN
  localparam bit PROTO = 1'b1;
`else
  localparam bit PROTO = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          snoop_valid;
  logic          snoop_ready;
  logic [2:0]    snoop_op;
  logic [AW-1:0] snoop_addr;
  logic          line_hit;
  states_t       line_mesi;
  logic          result_valid;
  snoop_result_t snoop_result;
  logic          mesi_we;
  states_t       mesi_next;
  logic          wb_valid;
  logic          wb_ready;
  logic [AW-1:0] wb_addr;
  logic          wb_last;
  logic          proto_err;

  int total  = 0;
  int passed = 0;

  snoop_responder #(.WB_BEATS(N), .ADDR_W(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .snoop_valid  (snoop_valid),
    .snoop_ready  (snoop_ready),
    .snoop_op     (snoop_op),
    .snoop_addr   (snoop_addr),
    .line_hit     (line_hit),
    .line_mesi    (line_mesi),
    .result_valid (result_valid),
    .snoop_result (snoop_result),
    .mesi_we      (mesi_we),
    .mesi_next    (mesi_next),
    .wb_valid     (wb_valid),
    .wb_ready     (wb_ready),
    .wb_addr      (wb_addr),
    .wb_last      (wb_last),
    .proto_err    (proto_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: what the snooping agent must answer, from the protocol rules.
  function automatic void ref_model(input logic [2:0] op, input logic hit, input states_t mesi,
                                    output logic [1:0] res, output logic we, output logic [1:0] nxt,
                                    output logic err, output logic wb);
    bit present;
    bit dirty;
    present = hit && (mesi != I);
    dirty   = present && (mesi == M);
    res = NOHIT; we = 1'b0; nxt = I; err = 1'b0; wb = 1'b0;
    if (present) begin
      if (op == 3'd1 || op == 3'd4) begin
        res = dirty ? HITM : HIT;
        we  = 1'b1;
        nxt = (op == 3'd1) ? S : I;
        wb  = dirty;
      end else if (op == 3'd3) begin
        we  = 1'b1;
        nxt = I;
        err = (mesi != S);
      end else begin
        err = 1'b1;
      end
    end
    if (!PROTO) err = 1'b0;
  endfunction

  task automatic check_idle_outputs(input string name);
    chk({name, ".ready"},    snoop_ready, 1'b1);
    chk({name, ".wb_valid"}, wb_valid, 1'b0);
    chk({name, ".wb_last"},  wb_last, 1'b0);
    chk({name, ".rvalid"},   result_valid, 1'b0);
    chk({name, ".mesi_we"},  mesi_we, 1'b0);
    chk({name, ".perr"},     proto_err, 1'b0);
  endtask

  // mode: 0 = wb_ready always high, 1 = 5-cycle stall on beat 3, 2 = random wb_ready.
  // hold: keep snoop_valid high (as a READ miss) across the whole transaction.
  task automatic do_snoop(input string name, input logic [2:0] op, input logic hit,
                          input states_t mesi, input logic [AW-1:0] addr,
                          input int mode, input bit hold);
    logic [1:0] e_res, e_nxt;
    logic       e_we, e_err, e_wb;
    int         beats, stalls, guard, stall_left, cyc;
    ref_model(op, hit, mesi, e_res, e_we, e_nxt, e_err, e_wb);
    chk({name, ".ready_idle"}, snoop_ready, 1'b1);
    snoop_valid = 1'b1;
    snoop_op    = op;
    line_hit    = hit;
    line_mesi   = mesi;
    snoop_addr  = addr;
    @(posedge clk); #1;
    cyc = 1;
    if (hold) begin
      snoop_op   = 3'd1;
      line_hit   = 1'b0;
      line_mesi  = states_t'($urandom_range(0, 3));
      snoop_addr = $urandom;
    end else begin
      snoop_valid = 1'b0;
    end
    wb_ready = 1'($urandom_range(0, 1));
    chk({name, ".rvalid"}, result_valid, 1'b1);
    chk({name, ".result"}, snoop_result, e_res);
    chk({name, ".mesi_we"}, mesi_we, e_we);
    if (e_we) chk({name, ".mesi_next"}, mesi_next, e_nxt);
    chk({name, ".perr"}, proto_err, e_err);
    chk({name, ".ready_resp"}, snoop_ready, 1'b0);
    chk({name, ".wbv_resp"}, wb_valid, 1'b0);
    beats = 0; stalls = 0; stall_left = 5; guard = 0;
    @(posedge clk); #1;
    cyc++;
    if (e_wb) begin
      while (beats < N && guard < 200) begin
        guard++;
        chk({name, ".wb_valid"}, wb_valid, 1'b1);
        chk({name, ".wb_addr"}, wb_addr, addr - (addr % N) + AW'(beats));
        chk({name, ".wb_last"}, wb_last, beats == N - 1);
        chk({name, ".ready_wb"}, snoop_ready, 1'b0);
        chk({name, ".rvalid_wb"}, result_valid, 1'b0);
        case (mode)
          0: wb_ready = 1'b1;
          1: begin
            if (beats == 3 && stall_left > 0) begin
              wb_ready = 1'b0;
              stall_left--;
            end else begin
              wb_ready = 1'b1;
            end
          end
          default: wb_ready = ($urandom_range(0, 3) != 0);
        endcase
        if (!wb_ready) stalls++;
        @(posedge clk); #1;
        cyc++;
        if (wb_ready) beats++;
      end
      chk({name, ".beats"}, beats, N);
    end
    wb_ready = 1'($urandom_range(0, 1));
    if (hold) begin
      chk({name, ".ready_back"}, snoop_ready, 1'b1);
      chk({name, ".no_capture"}, result_valid, 1'b0);
      @(posedge clk); #1;
      snoop_valid = 1'b0;
      chk({name, ".held_rvalid"}, result_valid, 1'b1);
      chk({name, ".held_result"}, snoop_result, NOHIT);
      chk({name, ".held_we"}, mesi_we, 1'b0);
      chk({name, ".held_ready"}, snoop_ready, 1'b0);
      @(posedge clk); #1;
    end
    check_idle_outputs(name);
    $display("txn %s op=%0d hit=%0d mesi=%0d addr=%h res=%0d wb=%0d stalls=%0d cycles=%0d",
             name, op, hit, mesi, addr, e_res, e_wb, stalls, cyc);
  endtask

  initial begin
    logic [AW-1:0] a;
    rst         = 1'b1;
    snoop_valid = 1'b0;
    snoop_op    = 3'd0;
    snoop_addr  = '0;
    line_hit    = 1'b0;
    line_mesi   = I;
    wb_ready    = 1'b0;
    #2;
    chk("reset.ready", snoop_ready, 1'b1);
    chk("reset.rvalid", result_valid, 1'b0);
    chk("reset.result", snoop_result, 2'd0);
    chk("reset.mesi_we", mesi_we, 1'b0);
    chk("reset.mesi_next", mesi_next, 2'd0);
    chk("reset.wb_valid", wb_valid, 1'b0);
    chk("reset.wb_addr", wb_addr, 32'd0);
    chk("reset.wb_last", wb_last, 1'b0);
    chk("reset.perr", proto_err, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;

    do_snoop("read_M",      3'd1, 1'b1, M, 32'h1000_0043, 0, 1'b0);
    do_snoop("rfo_E",       3'd4, 1'b1, E, 32'h2000_0010, 0, 1'b0);
    do_snoop("read_M_stall",3'd1, 1'b1, M, 32'hABCD_EF17, 1, 1'b0);
    do_snoop("inv_M",       3'd3, 1'b1, M, 32'h0000_0100, 0, 1'b0);
    do_snoop("inv_S",       3'd3, 1'b1, S, 32'h0000_0200, 0, 1'b0);
    do_snoop("inv_E",       3'd3, 1'b1, E, 32'h0000_0300, 0, 1'b0);
    do_snoop("write_S",     3'd2, 1'b1, S, 32'h0000_0400, 0, 1'b0);
    do_snoop("undef_E",     3'd7, 1'b1, E, 32'h0000_0500, 0, 1'b0);
    do_snoop("read_miss",   3'd1, 1'b0, M, 32'h0000_0600, 0, 1'b0);
    do_snoop("read_I",      3'd1, 1'b1, I, 32'h0000_0700, 0, 1'b0);
    do_snoop("read_E",      3'd1, 1'b1, E, 32'h0000_0800, 0, 1'b0);
    do_snoop("read_S",      3'd1, 1'b1, S, 32'h0000_0900, 0, 1'b0);
    do_snoop("rfo_M",       3'd4, 1'b1, M, 32'h5555_5555, 2, 1'b0);
    do_snoop("rfo_S",       3'd4, 1'b1, S, 32'h0000_0A00, 0, 1'b0);

    // Reset while beat 4 of a writeback is on the bus.
    a = 32'hCAFE_0008;
    snoop_valid = 1'b1; snoop_op = 3'd1; line_hit = 1'b1; line_mesi = M; snoop_addr = a;
    @(posedge clk); #1;
    snoop_valid = 1'b0;
    @(posedge clk); #1;
    wb_ready = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
    end
    chk("rstwb.beat4_addr", wb_addr, a - (a % N) + 32'd4);
    rst = 1'b1;
    #1;
    chk("rstwb.wb_valid", wb_valid, 1'b0);
    chk("rstwb.ready", snoop_ready, 1'b1);
    chk("rstwb.wb_addr", wb_addr, 32'd0);
    chk("rstwb.wb_last", wb_last, 1'b0);
    chk("rstwb.rvalid", result_valid, 1'b0);
    chk("rstwb.mesi_we", mesi_we, 1'b0);
    chk("rstwb.perr", proto_err, 1'b0);
    #1;
    rst = 1'b0;
    wb_ready = 1'b0;
    $display("txn reset_mid_wb addr=%h", a);
    do_snoop("post_rst_miss", 3'd1, 1'b0, S, 32'h0000_0B00, 0, 1'b0);

    do_snoop("hold_during_wb", 3'd1, 1'b1, M, 32'h3333_0020, 0, 1'b1);

    for (int k = 0; k < 40; k++) begin
      do_snoop($sformatf("rand%0d", k), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
               states_t'($urandom_range(0, 3)), $urandom, 2, 1'b0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
